// File: rtl/zbt_point_writer_pkg.sv
// Shared types and helpers for the ZBT point writer and its point FIFO.
package zbt_pkg;

  localparam int unsigned DEF_ADDR_W = 19;
  localparam int unsigned DEF_DATA_W = 36;
  localparam int unsigned DEF_TAG_W  = 10;
  localparam logic [DEF_TAG_W-1:0] DEF_TAG = 10'b1111111100;
  localparam int unsigned PACK_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    STOP = 2'd2
  } state_e;

  // Builds {x, y, tag} in the low bits of a wide word; the caller truncates to DATA_W.
  function automatic logic [PACK_W-1:0] pack_point(input logic [PACK_W-1:0] x,
                                                   input logic [PACK_W-1:0] y,
                                                   input logic [PACK_W-1:0] tag,
                                                   input int unsigned coord_w,
                                                   input int unsigned tag_w);
    return (x << (coord_w + tag_w)) | (y << tag_w) | tag;
  endfunction

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/zbt_point_writer_point_fifo.sv
// Synchronous FIFO whose head word is registered, so it can drive a bus directly.
module point_fifo import zbt_pkg::*; #(
  parameter int unsigned WIDTH = DEF_DATA_W,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   level,
  output logic [WIDTH-1:0] head
);

  localparam logic [PTR_W:0] LVL_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             full_q, full_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign do_pop  = pop & ~empty & ~flush;
  // A full FIFO still takes a push when the same cycle frees a slot.
  assign do_push = push & (~full_q | do_pop) & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    level_d  = level_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    head_d   = head_q;
    if (do_push && (empty || (do_pop && level_q == LVL_ONE))) begin
      head_d = push_data;
    end else if (do_pop && level_q > LVL_ONE) begin
      head_d = mem_q[rd_ptr_d];
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
    full_d = (level_d == LVL_FULL);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      head_q   <= head_d;
    end
  end

  assign full  = full_q;
  assign level = level_q;
  assign head  = head_q;

endmodule

// File: rtl/zbt_point_writer.sv
// Captures strobed (x,y) points into a FIFO and drains them into the ZBT write port.
module zbt_point_writer import zbt_pkg::*; #(
  parameter int unsigned COORD_W    = 11,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned TAG_W      = DEF_TAG_W,
  parameter logic [TAG_W-1:0] TAG   = DEF_TAG,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned MAX_POINTS = 50,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          WRAP       = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               point_valid,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               frame_start,
  input  logic               wr_grant,
  output logic               wr_req,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic [ADDR_W-1:0]  max_addr,
  output logic [ADDR_W-1:0]  point_count,
  output logic               fifo_full,
  output logic               overflow,
  output logic               done,
  output state_e             dbg_state
);

  localparam int unsigned LVL_W = clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MAX_POINTS - 1);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] CNT_MAX  = '1;

  if (DATA_W < 2 * COORD_W + TAG_W) begin : g_bad_data_w
    $error("DATA_W too small for {x, y, TAG}");
  end
  if (MAX_POINTS == 0 || ((64'(BASE_ADDR) + 64'(MAX_POINTS) - 64'd1) >> ADDR_W) != 64'd0) begin : g_bad_range
    $error("BASE_ADDR + MAX_POINTS - 1 does not fit in ADDR_W");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  state_e            state_q, state_d;
  logic              prev_valid_q, prev_valid_d;
  logic              wr_req_q, wr_req_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, index_q, index_d;
  logic [ADDR_W-1:0] max_addr_q, max_addr_d, count_q, count_d;
  logic              overflow_q, overflow_d, done_q, done_d;

  logic              capture, push, pop, flush, push_ok, drop, more;
  logic              fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  logic [DATA_W-1:0] point_word;

  assign point_word = DATA_W'(pack_point(PACK_W'(x), PACK_W'(y), PACK_W'(TAG), COORD_W, TAG_W));
  assign capture    = point_valid & ~prev_valid_q;
  assign push       = capture & ~done_q & ~frame_start;
  // wr_req/wr_grant: while wr_req is high, wr_addr/wr_data stay stable; a cycle with
  // wr_req and wr_grant both high completes exactly one write.
  assign pop        = (state_q == REQ) & wr_grant;
  assign flush      = frame_start | (state_q == STOP);
  assign push_ok    = push & (~fifo_full | pop);
  assign drop       = push & ~push_ok;
  assign more       = (fifo_level > LVL_W'(1)) | push_ok;

  point_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (point_word),
    .pop       (pop),
    .flush     (flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .head      (wr_data)
  );

  always_comb begin
    prev_valid_d = point_valid;
    state_d      = state_q;
    wr_req_d     = wr_req_q;
    wr_addr_d    = wr_addr_q;
    index_d      = index_q;
    max_addr_d   = max_addr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    done_d       = done_q;
    if (frame_start) begin
      state_d    = IDLE;
      wr_req_d   = 1'b0;
      wr_addr_d  = BASE;
      index_d    = '0;
      max_addr_d = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      done_d     = 1'b0;
    end else begin
      overflow_d = overflow_q | drop;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_d   = REQ;
            wr_req_d  = 1'b1;
            wr_addr_d = BASE + index_q;
          end
        end
        REQ: begin
          if (wr_grant) begin
            if (count_q != CNT_MAX) count_d = count_q + ONE_A;
            if (wr_addr_q > max_addr_q) max_addr_d = wr_addr_q;
            if (index_q == LAST_IDX && !WRAP) begin
              state_d  = STOP;
              wr_req_d = 1'b0;
              done_d   = 1'b1;
            end else begin
              index_d = (index_q == LAST_IDX) ? '0 : index_q + ONE_A;
              if (more) begin
                wr_addr_d = BASE + index_d;
              end else begin
                state_d  = IDLE;
                wr_req_d = 1'b0;
              end
            end
          end
        end
        STOP:    wr_req_d = 1'b0;
        default: state_d  = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      prev_valid_q <= 1'b0;
      wr_req_q     <= 1'b0;
      wr_addr_q    <= BASE;
      index_q      <= '0;
      max_addr_q   <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_valid_q <= prev_valid_d;
      wr_req_q     <= wr_req_d;
      wr_addr_q    <= wr_addr_d;
      index_q      <= index_d;
      max_addr_q   <= max_addr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      done_q       <= done_d;
    end
  end

  assign wr_req      = wr_req_q;
  assign wr_addr     = wr_addr_q;
  assign max_addr    = max_addr_q;
  assign point_count = count_q;
  assign overflow    = overflow_q;
  assign done        = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_zbt_point_writer.sv
// Bench for zbt_point_writer: one WRAP=0 and one WRAP=1 instance share all stimulus.
module tb_zbt_point_writer;
  import zbt_pkg::*;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 36;
  localparam int EW     = ADDR_W + DATA_W;
  localparam int BASE   = 0;
  localparam int MAXP   = 50;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        point_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic        wr_grant = 1'b0;
  logic [10:0] x = '0;
  logic [10:0] y = '0;

  logic              wr_req      [2];
  logic [ADDR_W-1:0] wr_addr     [2];
  logic [DATA_W-1:0] wr_data     [2];
  logic [ADDR_W-1:0] max_addr    [2];
  logic [ADDR_W-1:0] point_count [2];
  logic              fifo_full   [2];
  logic              overflow    [2];
  logic              done        [2];
  state_e            dbg_state   [2];

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  int frame_pts = 0;
  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    zbt_point_writer #(.WRAP(g == 1)) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .point_valid (point_valid),
      .x           (x),
      .y           (y),
      .frame_start (frame_start),
      .wr_grant    (wr_grant),
      .wr_req      (wr_req[g]),
      .wr_addr     (wr_addr[g]),
      .wr_data     (wr_data[g]),
      .max_addr    (max_addr[g]),
      .point_count (point_count[g]),
      .fifo_full   (fifo_full[g]),
      .overflow    (overflow[g]),
      .done        (done[g]),
      .dbg_state   (dbg_state[g])
    );
  end

  // ---------------- reference model ----------------
  function automatic logic [DATA_W-1:0] pack(input logic [10:0] px, input logic [10:0] py);
    return {4'b0000, px, py, 10'b1111111100};
  endfunction

  // Point n of a frame lands at index n (WRAP=0, first MAXP only) or n mod MAXP (WRAP=1).
  task automatic model_push(input logic [10:0] px, input logic [10:0] py);
    if (frame_pts < MAXP) exp_q0.push_back({ADDR_W'(BASE + frame_pts), pack(px, py)});
    exp_q1.push_back({ADDR_W'(BASE + frame_pts % MAXP), pack(px, py)});
    frame_pts++;
  endtask

  task automatic model_frame();
    exp_q0.delete();
    exp_q1.delete();
    frame_pts = 0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic check_write(input int k);
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    int sz;
    a  = {wr_addr[k], wr_data[k]};
    sz = (k == 0) ? exp_q0.size() : exp_q1.size();
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL dut%0d write: got unexpected write addr=%0d data=%0h, required no write",
               k, wr_addr[k], wr_data[k]);
    end else begin
      if (k == 0) e = exp_q0.pop_front();
      else        e = exp_q1.pop_front();
      chk($sformatf("dut%0d write {addr,data}", k), 64'(a), 64'(e));
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && !frame_start) begin
      for (int k = 0; k < 2; k++) begin
        if (wr_req[k] && wr_grant) check_write(k);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic g, input logic fs,
                       input logic [10:0] px, input logic [10:0] py);
    @(posedge clk);
    #1;
    point_valid = v;
    wr_grant    = g;
    frame_start = fs;
    x           = px;
    y           = py;
  endtask

  task automatic strobe(input logic [10:0] px, input logic [10:0] py,
                        input logic g, input bit accepted);
    if (accepted) model_push(px, py);
    drive(1'b1, g, 1'b0, px, py);
    drive(1'b0, g, 1'b0, px, py);
  endtask

  task automatic frame();
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    model_frame();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 300) begin
      drive(1'b0, 1'b1, 1'b0, '0, '0);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL %s drain: got %0d/%0d writes outstanding, required 0", tag,
               exp_q0.size(), exp_q1.size());
    end
    repeat (4) drive(1'b0, 1'b1, 1'b0, '0, '0);
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!(wr_req[0] && wr_req[1]) && n < 20) begin
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL %s wr_req: got %b%b, required 11", tag, wr_req[0], wr_req[1]);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s dut%0d wr_req", tag, k), 64'(wr_req[k]), 64'd0);
      chk($sformatf("%s dut%0d wr_addr", tag, k), 64'(wr_addr[k]), 64'(BASE));
      chk($sformatf("%s dut%0d wr_data", tag, k), 64'(wr_data[k]), 64'd0);
      chk($sformatf("%s dut%0d max_addr", tag, k), 64'(max_addr[k]), 64'd0);
      chk($sformatf("%s dut%0d point_count", tag, k), 64'(point_count[k]), 64'd0);
      chk($sformatf("%s dut%0d fifo_full", tag, k), 64'(fifo_full[k]), 64'd0);
      chk($sformatf("%s dut%0d overflow", tag, k), 64'(overflow[k]), 64'd0);
      chk($sformatf("%s dut%0d done", tag, k), 64'(done[k]), 64'd0);
    end
  endtask

  task automatic check_totals(input string tag, input bit exp_ovf);
    int cnt;
    int mx;
    for (int k = 0; k < 2; k++) begin
      cnt = (k == 0 && frame_pts > MAXP) ? MAXP : frame_pts;
      mx  = (frame_pts == 0) ? 0 : BASE + ((frame_pts > MAXP) ? MAXP : frame_pts) - 1;
      chk($sformatf("%s dut%0d point_count", tag, k), 64'(point_count[k]), 64'(cnt));
      chk($sformatf("%s dut%0d max_addr", tag, k), 64'(max_addr[k]), 64'(mx));
      chk($sformatf("%s dut%0d done", tag, k), 64'(done[k]), 64'(k == 0 && frame_pts >= MAXP));
      chk($sformatf("%s dut%0d overflow", tag, k), 64'(overflow[k]), 64'(exp_ovf));
      chk($sformatf("%s dut%0d wr_req idle", tag, k), 64'(wr_req[k]), 64'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [10:0] px_a [6];
  logic [10:0] py_a [6];

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single strobe with grant tied high, including the two-cycle request latency.
    model_push(11'd100, 11'd200);
    drive(1'b1, 1'b1, 1'b0, 11'd100, 11'd200);
    drive(1'b0, 1'b1, 1'b0, 11'd100, 11'd200);
    chk("latency N+1 wr_req", 64'(wr_req[0]), 64'd0);
    drive(1'b0, 1'b1, 1'b0, 11'd100, 11'd200);
    chk("latency N+2 wr_req", 64'(wr_req[0]), 64'd1);
    drain("single");
    check_totals("single", 1'b0);

    // Level held high for 20 cycles gives one capture.
    frame();
    model_push(11'd7, 11'd9);
    repeat (20) drive(1'b1, 1'b1, 1'b0, 11'd7, 11'd9);
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    drain("held");
    check_totals("held", 1'b0);

    // 60 random points with random grant; both limit behaviours at once.
    frame();
    for (int i = 0; i < 60; i++) begin
      int w;
      w = 0;
      while (exp_q1.size() >= DEPTH && w < 50) begin
        drive(1'b0, $urandom_range(0, 3) != 0, 1'b0, '0, '0);
        w++;
      end
      repeat ($urandom_range(0, 3)) drive(1'b0, $urandom_range(0, 3) != 0, 1'b0, '0, '0);
      strobe(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)),
             $urandom_range(0, 3) != 0, 1'b1);
    end
    drain("limit");
    check_totals("limit", 1'b0);

    // Grant held low: four points fill the FIFO, two more overflow.
    frame();
    for (int i = 0; i < 6; i++) begin
      px_a[i] = 11'($urandom_range(0, 2047));
      py_a[i] = 11'($urandom_range(0, 2047));
      strobe(px_a[i], py_a[i], 1'b0, i < DEPTH);
    end
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("stall%0d dut%0d fifo_full", r, k), 64'(fifo_full[k]), 64'd1);
        chk($sformatf("stall%0d dut%0d overflow", r, k), 64'(overflow[k]), 64'd1);
        chk($sformatf("stall%0d dut%0d wr_req", r, k), 64'(wr_req[k]), 64'd1);
        chk($sformatf("stall%0d dut%0d wr_addr", r, k), 64'(wr_addr[k]), 64'(BASE));
        chk($sformatf("stall%0d dut%0d wr_data", r, k), 64'(wr_data[k]), 64'(pack(px_a[0], py_a[0])));
      end
      repeat (3) drive(1'b0, 1'b0, 1'b0, '0, '0);
    end
    drain("overflow");
    check_totals("overflow", 1'b1);
    for (int k = 0; k < 2; k++)
      chk($sformatf("overflow dut%0d fifo_full after drain", k), 64'(fifo_full[k]), 64'd0);

    // frame_start while three points are queued and a request is pending.
    for (int i = 0; i < 3; i++)
      strobe(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)), 1'b0, 1'b1);
    wait_req("restart");
    frame();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("restart dut%0d wr_req", k), 64'(wr_req[k]), 64'd0);
      chk($sformatf("restart dut%0d point_count", k), 64'(point_count[k]), 64'd0);
      chk($sformatf("restart dut%0d max_addr", k), 64'(max_addr[k]), 64'd0);
      chk($sformatf("restart dut%0d overflow", k), 64'(overflow[k]), 64'd0);
      chk($sformatf("restart dut%0d fifo_full", k), 64'(fifo_full[k]), 64'd0);
    end
    strobe(11'd321, 11'd654, 1'b1, 1'b1);
    drain("restart");
    check_totals("restart", 1'b0);

    // Asynchronous reset in the middle of a pending request.
    strobe(11'd5, 11'd6, 1'b0, 1'b1);
    wait_req("async");
    reset_n = 1'b0;
    #1;
    check_reset_vals("async reset");
    model_frame();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) drive(1'b0, 1'b1, 1'b0, '0, '0);
    check_totals("after reset", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    checks++;
    errors++;
    $display("FAIL watchdog: got no completion by 500000, required earlier completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
